vm_arbiter: RTL

- Shares one vending core (coin pulse `a`, select/return pulse `b`, 3-bit `change`, 1-cycle `out`) between N_REQ front panels.
- Grants the core to one panel per transaction, chosen round-robin.
- Registers and forwards only the grantee's coin/select pulses.
- Routes change and the dispense pulse back to the grantee; releases on transaction end.

---
 rtl/vm_arb_pkg.sv | 19 +
 rtl/vm_rr_pick.sv | 37 +++
 rtl/vm_arbiter.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/vm_arb_pkg.sv
// vm_arb_pkg: shared types and defaults for the vending-core arbiter.
//   arb_state_t    : arbiter FSM state encoding
//   DefaultNReq    : default number of front panels
//   DefaultTimeout : default idle-cycle limit before a forced return
//   ChangeW        : width of the core's change amount
package vm_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StGrant,
    StDrain,
    StGap
  } arb_state_t;

  localparam int unsigned DefaultNReq    = 4;
  localparam int unsigned DefaultTimeout = 255;
  localparam int unsigned ChangeW        = 3;

endpackage

// File: rtl/vm_rr_pick.sv
// vm_rr_pick: combinational round-robin picker.
//   req_i    : request vector
//   ptr_i    : index of the previous winner; the scan starts one above it and wraps
//   onehot_o : one-hot winner (0 when no request)
//   idx_o    : binary index of the winner
//   any_o    : at least one request is set
module vm_rr_pick
  import vm_arb_pkg::*;
#(
  parameter int unsigned N_REQ = DefaultNReq,
  parameter int unsigned IdxW  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IdxW-1:0]  ptr_i,
  output logic [N_REQ-1:0] onehot_o,
  output logic [IdxW-1:0]  idx_o,
  output logic             any_o
);

  logic [N_REQ-1:0] req_sh;

  // Walk offsets from farthest to nearest so the nearest requester after ptr_i wins.
  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    req_sh   = '0;
    for (int k = int'(N_REQ); k >= 1; k--) begin
      req_sh = req_i >> ((int'(ptr_i) + k) % N_REQ);
      if (req_sh[0]) begin
        onehot_o = {{(N_REQ-1){1'b0}}, 1'b1} << ((int'(ptr_i) + k) % N_REQ);
        idx_o    = IdxW'((int'(ptr_i) + k) % N_REQ);
      end
    end
    any_o = |req_i;
  end

endmodule

// File: rtl/vm_arbiter.sv
// vm_arbiter: shares one vending core between N_REQ front panels, one transaction at a time.
//   clk, rst           : clock, asynchronous active-high reset (also resets the core)
//   req/coin/sel       : per-panel request level, coin pulse, select/return pulse
//   gnt                : registered one-hot grant
//   dispense           : one-cycle dispense pulse to the grantee
//   change_o/_valid    : change amount returned by the core, with 1-cycle qualifier
//   busy               : arbiter is not idle
//   core_a/core_b      : registered coin and select/return pulses to the core
//   core_change/out    : change and completion from the core
// Build option: define VM_ARB_TIMEOUT_EN to force a return after TIMEOUT idle cycles in GRANT.
module vm_arbiter
  import vm_arb_pkg::*;
#(
  parameter int unsigned N_REQ   = DefaultNReq,
  parameter int unsigned TIMEOUT = DefaultTimeout,
  parameter int unsigned TW      = $clog2(TIMEOUT + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ-1:0]   coin,
  input  logic [N_REQ-1:0]   sel,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   dispense,
  output logic [ChangeW-1:0] change_o,
  output logic               change_valid,
  output logic               busy,
  output logic               core_a,
  output logic               core_b,
  input  logic [ChangeW-1:0] core_change,
  input  logic               core_out
);

  localparam int unsigned IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_t         state_q, state_d;
  logic [IdxW-1:0]    ptr_q, ptr_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [N_REQ-1:0]   dispense_q, dispense_d;
  logic [ChangeW-1:0] change_q, change_d;
  logic               change_valid_q, change_valid_d;
  logic               core_a_q, core_a_d;
  logic               core_b_q, core_b_d;

  logic [N_REQ-1:0]   pick_onehot;
  logic [IdxW-1:0]    pick_idx;
  logic               pick_any;

  logic               g_coin, g_sel, g_req;

`ifdef VM_ARB_TIMEOUT_EN
  logic [TW-1:0]      tmo_q, tmo_d;
`else
  logic               unused_cfg;
  assign unused_cfg = ^TW'(TIMEOUT);
`endif

  vm_rr_pick #(
    .N_REQ (N_REQ),
    .IdxW  (IdxW)
  ) u_pick (
    .req_i    (req),
    .ptr_i    (ptr_q),
    .onehot_o (pick_onehot),
    .idx_o    (pick_idx),
    .any_o    (pick_any)
  );

  // The pointer always holds the current grantee's index once granted.
  assign g_coin = coin[ptr_q];
  assign g_sel  = sel[ptr_q];
  assign g_req  = req[ptr_q];

  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    gnt_d          = gnt_q;
    dispense_d     = '0;
    change_d       = '0;
    change_valid_d = 1'b0;
    core_a_d       = 1'b0;
    core_b_d       = 1'b0;
`ifdef VM_ARB_TIMEOUT_EN
    tmo_d          = tmo_q;
`endif

    if ((state_q == StGrant || state_q == StDrain) && core_change != '0) begin
      change_d       = core_change;
      change_valid_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        // core_out is ignored here: the core emits one after its own reset.
        if (pick_any) begin
          gnt_d   = pick_onehot;
          ptr_d   = pick_idx;
          state_d = StGrant;
`ifdef VM_ARB_TIMEOUT_EN
          tmo_d   = '0;
`endif
        end
      end
      StGrant: begin
        if (core_out) begin
          dispense_d = gnt_q;
          state_d    = StGap;
        end else begin
          core_a_d = g_coin;
          core_b_d = g_sel;
`ifdef VM_ARB_TIMEOUT_EN
          // Coin+select together is a core no-op, so it does not restart the timeout.
          tmo_d = (g_coin && !g_sel) ? '0 : tmo_q + 1'b1;
`endif
          if (g_sel) begin
            state_d = StDrain;
          end else if (!g_req) begin
            core_b_d = 1'b1;
            state_d  = StDrain;
          end
`ifdef VM_ARB_TIMEOUT_EN
          else if (!g_coin && tmo_q == TW'(TIMEOUT - 1)) begin
            core_b_d = 1'b1;
            state_d  = StDrain;
          end
`endif
        end
      end
      StDrain: begin
        if (core_out) begin
          dispense_d = gnt_q;
          state_d    = StGap;
        end
      end
      StGap: begin
        // Grant drops here so exactly one grant-free cycle precedes the next grant.
        gnt_d   = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      ptr_q          <= IdxW'(N_REQ - 1);
      gnt_q          <= '0;
      dispense_q     <= '0;
      change_q       <= '0;
      change_valid_q <= 1'b0;
      core_a_q       <= 1'b0;
      core_b_q       <= 1'b0;
`ifdef VM_ARB_TIMEOUT_EN
      tmo_q          <= '0;
`endif
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      gnt_q          <= gnt_d;
      dispense_q     <= dispense_d;
      change_q       <= change_d;
      change_valid_q <= change_valid_d;
      core_a_q       <= core_a_d;
      core_b_q       <= core_b_d;
`ifdef VM_ARB_TIMEOUT_EN
      tmo_q          <= tmo_d;
`endif
    end
  end

  assign gnt          = gnt_q;
  assign dispense     = dispense_q;
  assign change_o     = change_q;
  assign change_valid = change_valid_q;
  assign core_a       = core_a_q;
  assign core_b       = core_b_q;
  assign busy         = (state_q != StIdle);

endmodule
